// File: rtl/regfile_pkg.sv
// Shared types and default parameter values for the multi-port register file.
package regfile_pkg;

    localparam int DEF_DATA_W   = 32;
    localparam int DEF_ADDR_W   = 5;
    localparam int DEF_NUM_RD   = 2;
    localparam int DEF_ZERO_REG = 1;
    localparam int DEF_BYPASS   = 1;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } rf_state_e;

endpackage

// File: rtl/regfile_clear_seq.sv
// Initialisation sequencer: sweeps every entry to zero after reset or a clear
// request, then holds ready high until the next clear.
module regfile_clear_seq
    import regfile_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear_req,
    output logic              ready,
    output logic              clr_en,
    output logic [ADDR_W-1:0] clr_idx
);

    rf_state_e         state_reg;
    logic [ADDR_W-1:0] idx_reg;
    logic              ready_reg;
    logic              clr_en_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= CLEAR;
            idx_reg    <= '0;
            ready_reg  <= 1'b0;
            clr_en_reg <= 1'b1;
        end else begin
            case (state_reg)
                // clear_req is deliberately not looked at here, so a request
                // during the sweep cannot restart it.
                CLEAR: begin
                    if (idx_reg == {ADDR_W{1'b1}}) begin
                        state_reg  <= RUN;
                        idx_reg    <= '0;
                        ready_reg  <= 1'b1;
                        clr_en_reg <= 1'b0;
                    end else begin
                        idx_reg <= idx_reg + 1'b1;
                    end
                end
                RUN: begin
                    if (clear_req) begin
                        state_reg  <= CLEAR;
                        idx_reg    <= '0;
                        ready_reg  <= 1'b0;
                        clr_en_reg <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign ready   = ready_reg;
    assign clr_en  = clr_en_reg;
    assign clr_idx = idx_reg;

endmodule

// File: rtl/regfile_multi.sv
// Multi-read-port register file with optional hard-wired zero entry, optional
// write-to-read bypass and a self-timed clear sweep.
module regfile_multi
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NUM_RD   = DEF_NUM_RD,
    parameter int ZERO_REG = DEF_ZERO_REG,
    parameter int BYPASS   = DEF_BYPASS
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     reg_write,
    input  logic [ADDR_W-1:0]        write_reg,
    input  logic [DATA_W-1:0]        write_data,
    input  logic [NUM_RD*ADDR_W-1:0] read_reg,
    output logic [NUM_RD*DATA_W-1:0] read_data,
    input  logic                     clear_req,
    output logic                     ready
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic              clr_en;
    logic [ADDR_W-1:0] clr_idx;
    logic              wr_is_zero;
    logic              wr_accept;

    logic [DATA_W-1:0] registry [DEPTH];

    regfile_clear_seq #(
        .ADDR_W (ADDR_W)
    ) u_clear_seq (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_req (clear_req),
        .ready     (ready),
        .clr_en    (clr_en),
        .clr_idx   (clr_idx)
    );

    // A write to the zero entry is treated as never accepted, which keeps it
    // out of both the array and the bypass path.
    assign wr_is_zero = (ZERO_REG != 0) && (write_reg == '0);
    assign wr_accept  = ready && reg_write && !clear_req && !wr_is_zero;

    // Storage has no reset; the clear sweep is its only initialisation.
    always_ff @(posedge clk) begin
        if (clr_en) begin
            registry[clr_idx] <= '0;
        end else if (wr_accept) begin
            registry[write_reg] <= write_data;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
            logic [ADDR_W-1:0] rd_addr;
            logic [DATA_W-1:0] rd_data;

            assign rd_addr = read_reg[gi*ADDR_W +: ADDR_W];

            always_comb begin
                rd_data = registry[rd_addr];
                if (!ready) begin
                    rd_data = '0;
                end else if ((ZERO_REG != 0) && (rd_addr == '0)) begin
                    rd_data = '0;
                end else if ((BYPASS != 0) && wr_accept && (write_reg == rd_addr)) begin
                    rd_data = write_data;
                end
            end

            assign read_data[gi*DATA_W +: DATA_W] = rd_data;
        end
    endgenerate

endmodule

// File: tb/tb_regfile_multi.sv
// Scoreboard bench: stimulus queues expected read/ready values, a monitor on
// the falling edge pops and compares them against two DUTs (bypass on / off).
module tb_regfile_multi;

    logic        clk;
    logic        rst_n;
    logic        reg_write;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
    logic [9:0]  read_reg;
    logic        clear_req;
    logic [63:0] rd_bp;
    logic [63:0] rd_nb;
    logic        ready_bp;
    logic        ready_nb;

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   passed = 0;

    regfile_multi dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .reg_write  (reg_write),
        .write_reg  (write_reg),
        .write_data (write_data),
        .read_reg   (read_reg),
        .read_data  (rd_bp),
        .clear_req  (clear_req),
        .ready      (ready_bp)
    );

    regfile_multi #(
        .BYPASS (0)
    ) dut_nb (
        .clk        (clk),
        .rst_n      (rst_n),
        .reg_write  (reg_write),
        .write_reg  (write_reg),
        .write_data (write_data),
        .read_reg   (read_reg),
        .read_data  (rd_nb),
        .clear_req  (clear_req),
        .ready      (ready_nb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // sel: 0/1 = bypass DUT port 0/1, 2/3 = no-bypass DUT port 0/1,
    //      4 = bypass DUT ready, 5 = no-bypass DUT ready
    function automatic logic [31:0] pick(input int sel);
        case (sel)
            0:       return rd_bp[31:0];
            1:       return rd_bp[63:32];
            2:       return rd_nb[31:0];
            3:       return rd_nb[63:32];
            4:       return {31'd0, ready_bp};
            default: return {31'd0, ready_nb};
        endcase
    endfunction

    always @(negedge clk) begin
        while (sb_q.size() > 0) begin
            exp_t        e;
            logic [31:0] act;
            e   = sb_q.pop_front();
            act = pick(e.sel);
            checks++;
            if (act !== e.exp)
                $display("FAIL %s: got 0x%08h, expected 0x%08h", e.name, act, e.exp);
            else
                passed++;
        end
    end

    task automatic expect_val(input string name, input int sel, input logic [31:0] v);
        exp_t e;
        e.name = name;
        e.sel  = sel;
        e.exp  = v;
        sb_q.push_back(e);
    endtask

    task automatic check_now(input string name, input int sel, input logic [31:0] v);
        logic [31:0] act;
        act = pick(sel);
        checks++;
        if (act !== v) begin
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, v);
        end else begin
            passed++;
            $display("PASS %s: 0x%08h", name, act);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
        read_reg = {a1, a0};
    endtask

    task automatic idle();
        reg_write = 1'b0;
        clear_req = 1'b0;
    endtask

    // Called one edge into CLEAR (idx 0 still pending): 31 more low-ready
    // edges, then ready must rise on the 32nd.
    task automatic check_sweep(input string tag, input int pulse_at);
        for (int i = 1; i < 32; i++) begin
            step();
            clear_req = (i == pulse_at);
            expect_val({tag, "_ready_low"}, 4, 32'd0);
            expect_val({tag, "_ready_low_nb"}, 5, 32'd0);
        end
        step();
        clear_req = 1'b0;
        expect_val({tag, "_ready_high"}, 4, 32'd1);
        expect_val({tag, "_ready_high_nb"}, 5, 32'd1);
        check_now({tag, "_wait_expired_ready"}, 4, 32'd1);
    endtask

    task automatic do_write(input logic [4:0] a, input logic [31:0] d);
        step();
        reg_write  = 1'b1;
        write_reg  = a;
        write_data = d;
        step();
        reg_write  = 1'b0;
    endtask

    initial begin
        rst_n      = 1'b0;
        reg_write  = 1'b0;
        write_reg  = '0;
        write_data = '0;
        read_reg   = '0;
        clear_req  = 1'b0;

        // Reset state
        step();
        set_rd(5'd4, 5'd9);
        #1;
        check_now("reset_state_ready", 4, 32'd0);
        check_now("reset_state_rd0", 0, 32'd0);
        expect_val("reset_ready", 4, 32'd0);
        expect_val("reset_rd0", 0, 32'd0);
        expect_val("reset_rd1", 1, 32'd0);
        step();
        rst_n = 1'b1;
        expect_val("release_ready", 4, 32'd0);
        check_sweep("init", -1);

        // Every entry reads zero after the sweep
        for (int a = 0; a < 16; a++) begin
            set_rd(5'(a), 5'(a + 16));
            expect_val($sformatf("init_zero_%0d", a), 0, 32'd0);
            expect_val($sformatf("init_zero_%0d", a + 16), 1, 32'd0);
            step();
        end

        // Bypass of DEADBEEF to both ports in the write cycle
        reg_write  = 1'b1;
        write_reg  = 5'd5;
        write_data = 32'hDEADBEEF;
        set_rd(5'd5, 5'd5);
        expect_val("bypass_p0", 0, 32'hDEADBEEF);
        expect_val("bypass_p1", 1, 32'hDEADBEEF);
        expect_val("nobypass_p0_old", 2, 32'd0);
        step();
        reg_write = 1'b0;
        expect_val("persist_p0", 0, 32'hDEADBEEF);
        expect_val("persist_p1", 1, 32'hDEADBEEF);
        expect_val("persist_nb_p0", 2, 32'hDEADBEEF);
        expect_val("persist_nb_p1", 3, 32'hDEADBEEF);

        // Zero register ignores writes and is never bypassed
        step();
        reg_write  = 1'b1;
        write_reg  = 5'd0;
        write_data = 32'h12345678;
        set_rd(5'd0, 5'd5);
        expect_val("zero_same_cycle", 0, 32'd0);
        expect_val("zero_other_port", 1, 32'hDEADBEEF);
        step();
        reg_write = 1'b0;
        expect_val("zero_after", 0, 32'd0);
        expect_val("zero_after_nb", 2, 32'd0);

        // Bypass disabled: old value until the edge
        step();
        reg_write  = 1'b1;
        write_reg  = 5'd7;
        write_data = 32'h1;
        set_rd(5'd7, 5'd7);
        expect_val("nb_old_value", 2, 32'd0);
        expect_val("bp_new_value", 0, 32'h1);
        step();
        reg_write = 1'b0;
        expect_val("nb_next_cycle", 2, 32'h1);
        expect_val("nb_next_cycle_p1", 3, 32'h1);

        // clear_req with a concurrent write: write dropped, not bypassed
        do_write(5'd3, 32'h33333333);
        reg_write  = 1'b1;
        write_reg  = 5'd3;
        write_data = 32'hA5A5A5A5;
        clear_req  = 1'b1;
        set_rd(5'd3, 5'd7);
        expect_val("clr_no_bypass", 0, 32'h33333333);
        expect_val("clr_ready_still", 4, 32'd1);
        step();
        idle();
        expect_val("clr_ready_low", 4, 32'd0);
        expect_val("clr_rd_zero", 1, 32'd0);
        // A second clear_req mid-sweep must not stretch the sweep
        check_sweep("clr", 10);
        expect_val("clr_addr3_zero", 0, 32'd0);
        expect_val("clr_addr7_zero", 1, 32'd0);

        // Reset in the middle of a sweep
        do_write(5'd9, 32'h99999999);
        set_rd(5'd9, 5'd9);
        expect_val("pre_rst_val", 0, 32'h99999999);
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        for (int i = 0; i < 10; i++) step();
        rst_n = 1'b0;
        #1;
        check_now("rst_async_ready_drop", 4, 32'd0);
        check_now("rst_async_rd_zero", 0, 32'd0);
        expect_val("rst_ready_drop", 4, 32'd0);
        expect_val("rst_rd_zero", 0, 32'd0);
        step();
        rst_n = 1'b1;
        reg_write  = 1'b1;
        write_reg  = 5'd9;
        write_data = 32'h77777777;
        expect_val("rst_write_ignored_rd", 0, 32'd0);
        check_sweep("rst", -1);
        reg_write = 1'b0;
        expect_val("rst_write_lost", 0, 32'd0);
        expect_val("rst_write_lost_nb", 2, 32'd0);

        step();
        step();
        if (passed != checks)
            $display("FAIL summary: %0d/%0d checks passed", passed, checks);
        else
            $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/regfile_multi.md
REGFILE_MULTI -- requirements
Module: regfile_multi

Interface
REQ-001 Parameter DATA_W, default 32, bit width of each register.
REQ-002 Parameter ADDR_W, default 5, address width; DEPTH = 2**ADDR_W entries.
REQ-003 Parameter NUM_RD, default 2, number of independent read ports (1..8).
REQ-004 Parameter ZERO_REG, default 1; when 1, entry 0 reads as zero and ignores writes.
REQ-005 Parameter BYPASS, default 1; when 1, a same-cycle accepted write is forwarded to matching read ports.
REQ-006 Clocking SHALL be exactly: one clock; reset is asynchronous and active-low.
REQ-007 clk  input  1  sole clock; all state updates on rising edge.
REQ-008 rst_n  input  1  asynchronous, active-low reset.
REQ-009 reg_write  input  1  write enable.
REQ-010 write_reg  input  ADDR_W  write address.
REQ-011 write_data  input  DATA_W  write data.
REQ-012 read_reg  input  NUM_RD*ADDR_W  read addresses; port k uses bits [k*ADDR_W +: ADDR_W].
REQ-013 read_data  output  NUM_RD*DATA_W  read data; port k on bits [k*DATA_W +: DATA_W].
REQ-014 clear_req  input  1  one-cycle request to zero the whole array.
REQ-015 ready  output  1  high when the array is initialised and accepting writes.

Function
REQ-016 States: CLEAR (zeroing, ready=0) and RUN (ready=1); the state machine has no other states.
REQ-017 In CLEAR, one entry per clock SHALL be written to zero, index 0 up to DEPTH-1; after the edge that clears DEPTH-1, the state moves to RUN, so ready rises exactly DEPTH edges after CLEAR is entered.
REQ-018 In RUN, clear_req=1 at an edge SHALL move the state to CLEAR with index 0; in that same cycle the write is discarded and not bypassed.
REQ-019 clear_req in CLEAR SHALL be ignored and SHALL NOT restart the count.
REQ-020 A write is accepted only when ready=1, reg_write=1 and clear_req=0; registry[write_reg] updates at that edge.
REQ-021 Writes presented while ready=0 SHALL be dropped silently.
REQ-022 Reads are combinational on address and array contents: a change to either SHALL be reflected in the same cycle, not only on an address change.
REQ-023 While ready=0, every read_data port SHALL output zero.
REQ-024 With ZERO_REG=1: address 0 SHALL read zero; writes to address 0 are not stored and not bypassed.
REQ-025 With BYPASS=1: if a write is accepted and write_reg equals read port k's address, read_data[k] SHALL equal write_data in that cycle.
REQ-026 With BYPASS=0: that read port SHALL return the old value until the edge.
REQ-027 All read ports are independent; identical addresses on several ports SHALL return identical data.

Reset
REQ-028 Asserting rst_n=0 SHALL force, asynchronously: state=CLEAR, index=0, ready=0, read_data=0.
REQ-029 After rst_n deasserts, clearing starts at the first rising edge and ready rises after DEPTH edges.
REQ-030 Reset during CLEAR or RUN SHALL restart the sequence from index 0.
REQ-031 Array storage is not reset by flops; it is initialised only by the CLEAR sequence (no file preload).

Structure
REQ-032 Package regfile_pkg SHALL hold the state enum (CLEAR, RUN) and the default parameter constants.
REQ-033 Sub-module regfile_clear_seq SHALL contain the state machine and the index counter, outputting ready, clr_en and clr_idx.
REQ-034 regfile_multi SHALL contain the array, write mux (clear versus user write), read muxes and bypass.

Verification
REQ-035 Reset release with DEPTH=32 -> ready=0 for 32 edges, then 1; all 32 addresses read 0x00000000.
REQ-036 Write 0xDEADBEEF to address 5 in RUN, read port 0=5 and port 1=5 in the same cycle -> both read 0xDEADBEEF (BYPASS=1); the value persists next cycle.
REQ-037 Write 0x12345678 to address 0 with ZERO_REG=1 -> address 0 reads 0 in the same cycle and afterwards.
REQ-038 clear_req together with a write of 0xA5A5A5A5 to address 3 -> write dropped; ready=0 for 32 edges; address 3 then reads 0.
REQ-039 rst_n pulsed low at clear index 10 -> ready drops at once; a full 32-edge clear follows; a write attempted during the clear is lost.
REQ-040 BYPASS=0, write 0x1 to address 7 with port 0 reading address 7 -> old value in that cycle, 0x1 from the next cycle.
